// File: rtl/ddr2_arb_pkg.sv
// ddr2_arb_pkg: command codes, read tag record and burst sizing shared by the DDR2 command arbiter
package ddr2_arb_pkg;
    typedef enum logic [2:0] {
        NOP = 3'd0,
        SCR = 3'd1,
        SCW = 3'd2,
        BLR = 3'd3,
        BLW = 3'd4,
        ATR = 3'd5,
        ATW = 3'd6
    } cmd_e;

    typedef struct packed {
        logic [2:0] id;
        logic [5:0] words;
    } tag_t;

    localparam int FILL_MAX_DEF = 64;
    localparam int HEADROOM_DEF = 2;

    function automatic logic [5:0] burst_words(input logic [2:0] c, input logic [1:0] s);
        return (c == BLR || c == BLW) ? {1'b0, s, 3'b000} + 6'd8 : 6'd1;
    endfunction

    function automatic logic is_read(input logic [2:0] c);
        return c == SCR || c == BLR || c == ATR;
    endfunction
endpackage

// File: rtl/ddr2_tag_fifo.sv
// ddr2_tag_fifo: in-order FIFO of outstanding read tags; push and pop may coincide even when full
module ddr2_tag_fifo
    import ddr2_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  tag_t                       wdata,
    input  logic                       pop,
    output tag_t                       rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     cnt
);
    localparam int AW = $clog2(DEPTH);

    tag_t mem [DEPTH];
    logic [AW:0] wp, rp;
    logic do_push, do_pop;

    assign cnt     = wp - rp;
    assign empty   = cnt == '0;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
        end

    always_ff @(posedge clk)
        if (do_push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/ddr2_cmd_arbiter.sv
// ddr2_cmd_arbiter: round-robin sharing of the DDR2 controller host port, with block-write
// streaming and in-order routing of read returns back to the issuing requester
module ddr2_cmd_arbiter
    import ddr2_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 8,
    parameter int FILL_MAX  = FILL_MAX_DEF,
    parameter int HEADROOM  = HEADROOM_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0][2:0]   req_cmd,
    input  logic [NUM_REQ-1:0][1:0]   req_sz,
    input  logic [NUM_REQ-1:0][2:0]   req_op,
    input  logic [NUM_REQ-1:0][24:0]  req_addr,
    input  logic [NUM_REQ-1:0][15:0]  req_din,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        wdata_pop,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [15:0]               rsp_data,
    output logic [24:0]               rsp_addr,
    output logic [2:0]                cmd,
    output logic [1:0]                sz,
    output logic [2:0]                op,
    output logic [15:0]               din,
    output logic [24:0]               addr,
    output logic                      fetching,
    input  logic [6:0]                fillcount,
    input  logic                      notfull,
    input  logic [15:0]               dout,
    input  logic [24:0]               raddr,
    input  logic                      validout,
    output logic                      busy,
    output logic                      err_unexp_rsp
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int AW = $clog2(TAG_DEPTH);

    typedef enum logic {ARB, WDATA} state_e;

    state_e               state;
    logic                 g_valid, found, decide, tag_block, tag_full, tag_empty, push, pop, hit;
    logic [IW-1:0]        g_id, ptr, off, win;
    logic [IW:0]          sum;
    logic [2:0]           g_cmd;
    logic [5:0]           g_words, wcnt, rcnt;
    logic [NUM_REQ-1:0]   elig, g_hot;
    logic [2*NUM_REQ-1:0] elig_rot;
    logic [AW:0]          tag_cnt;
    tag_t                 head, push_tag;

    // A read in its issue cycle has not reached the FIFO yet, so reserve its slot now
    assign tag_block = tag_full | (g_valid & is_read(g_cmd) & (tag_cnt == (AW+1)'(TAG_DEPTH - 1)));

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = req_valid[i] & notfull & ~(g_valid & (g_id == IW'(i))) &
                      (is_read(req_cmd[i]) ? ~tag_block :
                       req_cmd[i] == BLW ? (8'(fillcount) + 8'(burst_words(req_cmd[i], req_sz[i])) +
                                            8'(HEADROOM) <= 8'(FILL_MAX)) :
                       (req_cmd[i] == SCW || req_cmd[i] == ATW));
    end

    assign elig_rot = {elig, elig} >> ptr;

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (elig_rot[k]) begin
                found = 1'b1;
                off   = IW'(k);
            end
    end

    assign sum    = {1'b0, ptr} + {1'b0, off};
    assign win    = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ)) : sum[IW-1:0];
    assign decide = (state == ARB) & found;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state   <= ARB;
            g_valid <= 1'b0;
            g_id    <= '0;
            g_cmd   <= '0;
            g_words <= '0;
            ptr     <= '0;
            wcnt    <= '0;
        end else begin
            g_valid <= decide;
            if (decide) begin
                g_id    <= win;
                g_cmd   <= req_cmd[win];
                g_words <= burst_words(req_cmd[win], req_sz[win]);
                ptr     <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                wcnt    <= '0;
                state   <= (req_cmd[win] == BLW) ? WDATA : ARB;
            end else if (state == WDATA) begin
                wcnt <= wcnt + 6'd1;
                if (wcnt == g_words - 6'd1) state <= ARB;
            end
        end

    assign g_hot     = NUM_REQ'(1) << g_id;
    assign fetching  = g_valid | (state == WDATA);
    assign cmd       = g_valid ? g_cmd : '0;
    assign req_ready = g_valid ? g_hot : '0;
    assign wdata_pop = fetching ? g_hot : '0;
    assign din       = fetching ? req_din[g_id] : '0;
    assign sz        = g_valid ? req_sz[g_id] : '0;
    assign op        = g_valid ? req_op[g_id] : '0;
    assign addr      = g_valid ? req_addr[g_id] : '0;

    assign push     = g_valid & is_read(g_cmd);
    assign push_tag = '{id: 3'(g_id), words: g_words};
    assign hit      = validout & ~tag_empty;
    assign pop      = hit & (rcnt + 6'd1 == head.words);

    ddr2_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (push_tag),
        .pop   (pop),
        .rdata (head),
        .full  (tag_full),
        .empty (tag_empty),
        .cnt   (tag_cnt)
    );

    assign rsp_valid = hit ? NUM_REQ'(1) << head.id : '0;
    assign rsp_data  = hit ? dout : '0;
    assign rsp_addr  = hit ? raddr : '0;
    assign busy      = (state != ARB) | ~tag_empty;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            rcnt          <= '0;
            err_unexp_rsp <= 1'b0;
        end else begin
            if (hit) rcnt <= pop ? '0 : rcnt + 6'd1;
            if (validout & tag_empty) err_unexp_rsp <= 1'b1;
        end
endmodule

// File: doc/ddr2_cmd_arbiter.md
Name: ddr2_cmd_arbiter

Overview:
Shares the single DDR2 controller host command port (cmd/sz/op/din/addr/fetching in, notfull/fillcount out) between NUM_REQ independent requesters. Uses round-robin arbitration, streams block-write data and gates issue on controller queue space. Tracks outstanding reads in an in-order tag FIFO and routes the controller's dout/raddr/validout return stream back to the originating requester. Sits between the traffic sources (driver/bench agents) and ddr2_controller.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
TAG_DEPTH, 8, outstanding read commands tracked (power of 2)
FILL_MAX, 64, controller command/data queue capacity in entries
HEADROOM, 2, extra free entries required beyond burst length before issuing a block write

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  requester i has a command pending
req_cmd  in  NUM_REQ x 3  command code per requester
req_sz  in  NUM_REQ x 2  burst size code
req_op  in  NUM_REQ x 3  atomic op code
req_addr  in  NUM_REQ x 25  word address
req_din  in  NUM_REQ x 16  write data word currently offered
req_ready  out  NUM_REQ  one-hot; command of requester i accepted this cycle
wdata_pop  out  NUM_REQ  one-hot; req_din of requester i consumed this cycle
rsp_valid  out  NUM_REQ  one-hot; read data for requester i on rsp_data
rsp_data  out  16  routed read data
rsp_addr  out  25  routed read address
cmd, sz, op, din, addr, fetching  out  3/2/3/16/25/1  to ddr2_controller
fillcount  in  7  controller queue occupancy
notfull  in  1  controller can accept an entry
dout, raddr, validout  in  16/25/1  controller read return
busy  out  1  burst in progress or tags outstanding
err_unexp_rsp  out  1  sticky: validout with tag FIFO empty

Behaviour:
- Reset (reset=0, async): all outputs 0, cmd=NOP, FSM=ARB, RR pointer=0, tag FIFO empty, error flag clear. Reset mid-burst aborts the burst; no recovery.
- Command codes: NOP=0, SCR=1, SCW=2, BLR=3, BLW=4, ATR=5, ATW=6; codes 7 and NOP with req_valid=1 are treated as NOP. Burst words = 8*(sz+1) for BLR/BLW; 1 otherwise.
- Eligibility of requester i in ARB: req_valid[i] & notfull &
  - reads (SCR, BLR, ATR): tag FIFO not full;
  - BLW: fillcount + words + HEADROOM <= FILL_MAX (8-bit compare);
  - SCW/ATW: notfull only.
- Arbitration: round-robin starting at RR pointer. Grant is registered; cmd/sz/op/addr/din/fetching are driven the cycle after the decision, with req_ready[i]=1 and wdata_pop[i]=1 in that same issue cycle. RR pointer <= winner+1 (mod NUM_REQ) on every grant. Nothing eligible: cmd=NOP, fetching=0, pointer holds.
- Issue cycle: fetching=1. Reads push {id, words} into the tag FIFO. ATW/SCW carry req_din as their single word.
- BLW: the issue cycle carries word 0. FSM -> WDATA, then words 1..N-1 on consecutive cycles: din=req_din[id], wdata_pop[id]=1, cmd=NOP, fetching=1. Requesters keep data valid every cycle once granted. On the last word the FSM returns to ARB, so there is one idle cycle before the next grant. No other grant is made during WDATA.
- Return path: on each validout cycle, rsp_valid[head.id]=1 and rsp_data/rsp_addr = dout/raddr, combinational same cycle. A per-head word counter increments; on reaching head.words the FIFO pops and the counter clears. A tag push and a pop in the same cycle are both legal, including when the FIFO is full.
- validout with an empty FIFO: rsp_valid all 0, err_unexp_rsp set until reset.
- busy = (FSM != ARB) | tag FIFO non-empty.

Decomposition:
- ddr2_arb_pkg holds:
  - cmd_e enum of the command codes;
  - tag_t struct {id, words[5:0]};
  - function burst_words(cmd, sz);
  - FILL_MAX/HEADROOM defaults.
- One sub-module, ddr2_tag_fifo: synchronous FIFO of tag_t with full/empty and simultaneous push/pop.

Test Plan:
1. Reset held low mid-BLW (word 5 of 8) -> all outputs 0 immediately; after release cmd=NOP and busy=0.
2. All 4 requesters issue SCW continuously, notfull=1 -> grant order 0,1,2,3,0,...; exactly one req_ready per issue cycle.
3. Requester 2 issues BLW sz=1 -> 16 consecutive fetching cycles, cmd=BLW only in the first; 16 wdata_pop[2] pulses; next grant no earlier than 1 cycle later.
4. fillcount=48 with BLW sz=1 pending -> not granted (48+16+2>64); drop fillcount to 46 -> granted.
5. Req 0 BLR sz=0 then req 3 SCR; controller returns 9 validout words -> the first 8 words assert rsp_valid[0], the 9th asserts rsp_valid[3]; busy falls after the last word.
6. Fill the tag FIFO with 8 SCRs -> 9th read is held until one validout pops a tag. Separately, validout with the FIFO empty -> err_unexp_rsp=1 and sticky.
